// File: rtl/serial_tmr_adder.sv
// rtl/serial_tmr_adder.sv - bit-serial adder with three voted full-adder copies and fault flagging
// Operands shift in LSB-first; a shared carry register is fed from the voted carry.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_tmr_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       fi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fault,
    output logic [CNT_W-1:0] fault_cnt
);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry_q;
    logic [2:0]       s_raw;
    logic [2:0]       c_raw;
    logic [2:0]       s_cp;
    logic [2:0]       c_cp;
    logic             s_vote;
    logic             c_vote;
    logic             disagree;
    logic             last_bit;
    logic             accept;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    for (genvar j = 0; j < 3; j++) begin : g_copy
        full_adder u_fa (
            .a  (a_sh[0]),
            .b  (b_sh[0]),
            .ci (carry_q),
            .s  (s_raw[j]),
            .co (c_raw[j])
        );
    end

    // Injected faults corrupt both outputs of a copy so voting sees a whole bad cell.
    assign s_cp     = s_raw ^ fi;
    assign c_cp     = c_raw ^ fi;
    assign s_vote   = maj3(s_cp);
    assign c_vote   = maj3(c_cp);
    assign disagree = ((s_cp != 3'b000) && (s_cp != 3'b111)) ||
                      ((c_cp != 3'b000) && (c_cp != 3'b111));
    assign last_bit = (bit_cnt == BW'(WIDTH - 1));
    assign accept   = (state == S_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            carry_q   <= 1'b0;
            bit_cnt   <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            fault     <= 1'b0;
            fault_cnt <= '0;
        end else if (accept) begin
            a_sh      <= a;
            b_sh      <= b;
            carry_q   <= cin;
            bit_cnt   <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            fault     <= 1'b0;
            fault_cnt <= '0;
        end else if (state == S_RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            carry_q <= c_vote;
            bit_cnt <= bit_cnt + 1'b1;
            sum     <= {s_vote, sum[WIDTH-1:1]};
            if (disagree) begin
                fault <= 1'b1;
                if (fault_cnt != '1) begin
                    fault_cnt <= fault_cnt + 1'b1;
                end
            end
            if (last_bit) begin
                cout <= c_vote;
            end
        end
    end
endmodule
